// File: rtl/glip_pattern_gen_check.sv
// glip_pattern_gen_check
// Traffic source and checker for the GLIP FIFO user interface.
//  - Source: drives an incrementing word stream (starting at SEED) to the host.
//  - Sink: consumes words from the host and checks that they also increment,
//    locking onto the phase of the first word it sees after enable.
//  - Statistics (word count, saturating error count, sticky error and the
//    first mismatching pair) feed the LCD/debug path.
// Optional feature: define GLIP_PATTERN_STALL_INJECT_EN to force both
// handshakes low every 4th cycle, which exercises backpressure in the GLIP FIFOs.
module glip_pattern_gen_check #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             gen_en,
    input  logic             chk_en,
    output logic [WIDTH-1:0] fifo_out_data,
    output logic             fifo_out_valid,
    input  logic             fifo_out_ready,
    input  logic [WIDTH-1:0] fifo_in_data,
    input  logic             fifo_in_valid,
    output logic             fifo_in_ready,
    output logic [31:0]      word_cnt,
    output logic [15:0]      err_cnt,
    output logic             error,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] gen_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] exp_s;
    logic [31:0]      word_cnt_r;
    logic [31:0]      word_cnt_s;
    logic [15:0]      err_cnt_r;
    logic [15:0]      err_cnt_s;
    logic             error_r;
    logic             error_s;
    logic [WIDTH-1:0] fe_exp_r;
    logic [WIDTH-1:0] fe_exp_s;
    logic [WIDTH-1:0] fe_got_r;
    logic [WIDTH-1:0] fe_got_s;
    logic             stall_s;
    logic             out_valid_s;
    logic             in_ready_s;
    logic             out_xfer_s;
    logic             in_acc_s;

`ifdef GLIP_PATTERN_STALL_INJECT_EN
    logic [1:0] stall_cnt_r;

    // Free-running phase counter for stall injection; clear deliberately does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 2'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + 2'd1;
        end
    end

    assign stall_s = (stall_cnt_r == 2'd3);
`else
    assign stall_s = 1'b0;
`endif

    // Handshakes: clear blocks both sides so nothing moves during the restart cycle.
    assign out_valid_s = gen_en & ~clear & ~stall_s;
    assign in_ready_s  = chk_en & ~clear & ~stall_s & (state_r != ST_IDLE);
    assign out_xfer_s  = out_valid_s & fifo_out_ready;
    assign in_acc_s    = fifo_in_valid & in_ready_s;

    assign fifo_out_data  = gen_r;
    assign fifo_out_valid = out_valid_s;
    assign fifo_in_ready  = in_ready_s;
    assign word_cnt       = word_cnt_r;
    assign err_cnt        = err_cnt_r;
    assign error          = error_r;
    assign first_err_exp  = fe_exp_r;
    assign first_err_got  = fe_got_r;

    // Generator counter: restarts at SEED on clear, advances on each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_r <= SEED;
        end else if (clear) begin
            gen_r <= SEED;
        end else if (out_xfer_s) begin
            gen_r <= gen_r + ONE;
        end else begin
            gen_r <= gen_r;
        end
    end

    // Checker next state: clear restarts straight into SYNC when checking stays enabled.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = chk_en ? ST_SYNC : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = chk_en ? ST_SYNC : ST_IDLE;
                end
                ST_SYNC: begin
                    if (!chk_en) begin
                        state_nxt_s = ST_IDLE;
                    end else if (in_acc_s) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_CHECK: begin
                    state_nxt_s = chk_en ? ST_CHECK : ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Statistics next values: SYNC only sets the phase, CHECK compares and resyncs on mismatch.
    always_comb begin
        exp_s      = exp_r;
        word_cnt_s = word_cnt_r;
        err_cnt_s  = err_cnt_r;
        error_s    = error_r;
        fe_exp_s   = fe_exp_r;
        fe_got_s   = fe_got_r;
        if (clear) begin
            exp_s      = ZERO;
            word_cnt_s = 32'd0;
            err_cnt_s  = 16'd0;
            error_s    = 1'b0;
            fe_exp_s   = ZERO;
            fe_got_s   = ZERO;
        end else if (in_acc_s) begin
            word_cnt_s = word_cnt_r + 32'd1;
            case (state_r)
                ST_SYNC: begin
                    exp_s = fifo_in_data + ONE;
                end
                ST_CHECK: begin
                    if (fifo_in_data == exp_r) begin
                        exp_s = exp_r + ONE;
                    end else begin
                        exp_s = fifo_in_data + ONE;
                        if (err_cnt_r != 16'hFFFF) begin
                            err_cnt_s = err_cnt_r + 16'd1;
                        end else begin
                            err_cnt_s = err_cnt_r;
                        end
                        if (!error_r) begin
                            error_s  = 1'b1;
                            fe_exp_s = exp_r;
                            fe_got_s = fifo_in_data;
                        end else begin
                            error_s  = error_r;
                        end
                    end
                end
                default: begin
                    // IDLE never accepts because ready is low there
                    word_cnt_s = word_cnt_r;
                end
            endcase
        end else begin
            exp_s = exp_r;
        end
    end

    // Checker state and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            exp_r      <= ZERO;
            word_cnt_r <= 32'd0;
            err_cnt_r  <= 16'd0;
            error_r    <= 1'b0;
            fe_exp_r   <= ZERO;
            fe_got_r   <= ZERO;
        end else begin
            state_r    <= state_nxt_s;
            exp_r      <= exp_s;
            word_cnt_r <= word_cnt_s;
            err_cnt_r  <= err_cnt_s;
            error_r    <= error_s;
            fe_exp_r   <= fe_exp_s;
            fe_got_r   <= fe_got_s;
        end
    end

endmodule
